rom_frame_streamer: RTL and testbench
=====================================

Name: rom_frame_streamer

Overview:
Raster-scans a full WIDTH×HEIGHT image held in an external synchronous ROM and emits it as a pixel stream with valid/ready backpressure. It generalises the single-pixel coordinate reader: ROM latency, pixel width and image size are parametrised, frames are started by command, horizontal and vertical flip modes exist, and an internal credit-based FIFO absorbs in-flight reads. It sits between the input image ROM and the downstream thresholding pipeline.

Parameters:
WIDTH_BITS, 8, log2 image width (width = 2**WIDTH_BITS)
HEIGHT_BITS, 8, log2 image height
PIXEL_BITS, 8, pixel data width
ROM_LATENCY, 1, cycles from oRomAddr to valid iRomData (1..4)
FIFO_DEPTH, 4, output FIFO entries; must be ≥ ROM_LATENCY+1, power of two

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
iStart  in  1  one-cycle pulse; begins a frame when idle
iFlipH  in  1  mirror columns; sampled on accepted iStart
iFlipV  in  1  mirror rows; sampled on accepted iStart
oBusy  out  1  high from accepted iStart until last pixel handed off
oDone  out  1  one-cycle pulse after last pixel handed off
oRomAddr  out  WIDTH_BITS+HEIGHT_BITS  ROM address
iRomData  in  PIXEL_BITS  ROM read data, ROM_LATENCY cycles after address
oValid  out  1  output pixel valid
iReady  in  1  downstream ready
oData  out  PIXEL_BITS  pixel value
oCol  out  WIDTH_BITS  output-order column
oRow  out  HEIGHT_BITS  output-order row
oSof  out  1  first pixel of frame
oEol  out  1  last pixel of a row
oEof  out  1  last pixel of frame

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, FIFO empty, in-flight pipe cleared; oBusy=0, oDone=0, oValid=0, oRomAddr=0, oData/oCol/oRow=0, oSof/oEol/oEof=0.
- States: IDLE → (iStart) ISSUE → (last address issued) DRAIN → (last pixel handshaken) DONE → IDLE (one cycle; oDone=1). iStart ignored outside IDLE.
- Issue counter (col, row) starts at (0,0), increments col, wraps col at 2**WIDTH_BITS−1 to 0 and increments row; no wrap past last row.
- Storage coordinates: sc = iFlipH ? ~col : col; sr = iFlipV ? ~row : row (bitwise). oRomAddr = {sr, sc} = sr·2**WIDTH_BITS + sc, registered.
- Read issued in a cycle only if (FIFO count + in-flight count) < FIFO_DEPTH. In-flight tracked by a ROM_LATENCY-deep valid shift register carrying col/row/flags alongside; iRomData written to FIFO when the tagged slot exits. No read is ever dropped; FIFO never overflows.
- oCol/oRow report output-order (unmirrored) counters; oSof at (0,0); oEol at col=max; oEof at (max,max). All travel with data through the FIFO.
- Output: oValid = FIFO not empty; transfer when oValid && iReady. oData and tags stable while oValid && !iReady. FIFO is first-word-fall-through registered output; simultaneous push and pop allowed at any count including full-with-pop.
- Throughput: with iReady held high, one pixel per cycle after first-pixel latency of ROM_LATENCY+2 cycles from iStart.
- oBusy rises the cycle after accepted iStart, falls with oDone pulse.
- Flip flags held constant for the whole frame regardless of input changes.
- Reset mid-frame: all state discarded immediately; late ROM data ignored; next frame begins only on new iStart.
- iStart coinciding with DONE cycle is ignored.

Test Plan:
- WIDTH_BITS=HEIGHT_BITS=2, ROM[a]=a, iReady=1, iStart → 16 pixels, data 0..15 in order, oSof on first, oEol on data 3,7,11,15, oEof on 15, oDone one cycle later, first oValid ROM_LATENCY+2 cycles after iStart.
- Same, iFlipH=1 → data 3,2,1,0,7,6,…,12; iFlipV=1 only → 12,13,14,15,8,…,3; both → 15 down to 0; oCol/oRow always 0..3 raster.
- ROM_LATENCY=3, FIFO_DEPTH=4, iReady toggled random 30% → all 16 pixels exactly once in order, no data change while stalled, oRomAddr issues pause when count+in-flight=4.
- iReady=0 for 20 cycles after start → exactly 4 reads issued, oValid=1 with data 0 held; release → remaining 12 follow back-to-back.
- reset_n low at pixel 6 for one cycle → all outputs 0 immediately; no oDone; new iStart yields full frame from 0.
- iStart pulsed while busy and during oDone cycle → no effect; single frame of 16 pixels.

Source files
------------

// File: rtl/rom_frame_streamer.sv
// Raster-scans a WIDTH x HEIGHT image out of a synchronous ROM and streams it with
// valid/ready backpressure; credit-limited reads land in a small FWFT FIFO.
module rom_frame_streamer #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int PIXEL_BITS  = 8,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              iStart,
  input  logic                              iFlipH,
  input  logic                              iFlipV,
  output logic                              oBusy,
  output logic                              oDone,
  output logic [WIDTH_BITS+HEIGHT_BITS-1:0] oRomAddr,
  input  logic [PIXEL_BITS-1:0]             iRomData,
  output logic                              oValid,
  input  logic                              iReady,
  output logic [PIXEL_BITS-1:0]             oData,
  output logic [WIDTH_BITS-1:0]             oCol,
  output logic [HEIGHT_BITS-1:0]            oRow,
  output logic                              oSof,
  output logic                              oEol,
  output logic                              oEof
);

  // Stage 0 lines up with the registered address; the last stage lines up with iRomData.
  localparam int PL = ROM_LATENCY + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = WIDTH_BITS + HEIGHT_BITS + 3;
  localparam int CW = $clog2(FIFO_DEPTH + PL + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state;
  logic [WIDTH_BITS-1:0]  col;
  logic [HEIGHT_BITS-1:0] row;
  logic                   flip_h, flip_v;

  logic [PL-1:0]          vld_p;
  logic [TW-1:0]          tag_p [PL];

  logic [PIXEL_BITS-1:0]  mem_data [FIFO_DEPTH];
  logic [TW-1:0]          mem_tag  [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;

  logic                   can_issue, last_pos, push, pop, head_eof;
  logic [TW-1:0]          issue_tag;
  logic [WIDTH_BITS-1:0]  sc;
  logic [HEIGHT_BITS-1:0] sr;

  function automatic logic [CW-1:0] outstanding(input logic [PL-1:0] v, input logic [AW:0] c);
    logic [CW-1:0] s;
    s = CW'(c);
    for (int i = 0; i < PL; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  assign last_pos  = (&col) && (&row);
  assign can_issue = (state == ISSUE) && (outstanding(vld_p, count) < CW'(FIFO_DEPTH));
  assign sc        = flip_h ? ~col : col;
  assign sr        = flip_v ? ~row : row;
  assign issue_tag = {col, row, (col == '0) && (row == '0), &col, last_pos};

  assign push      = vld_p[PL-1];
  assign oValid    = (count != '0);
  assign pop       = oValid && iReady;
  assign head_eof  = mem_tag[rd_ptr][0];

  // Outputs read zero whenever the FIFO is empty, so unreset storage never leaks out.
  assign oData = oValid ? mem_data[rd_ptr] : '0;
  assign {oCol, oRow, oSof, oEol, oEof} = oValid ? mem_tag[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      flip_h   <= 1'b0;
      flip_v   <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oRomAddr <= '0;
      vld_p    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          state  <= ISSUE;
          oBusy  <= 1'b1;
          flip_h <= iFlipH;
          flip_v <= iFlipV;
          col    <= '0;
          row    <= '0;
        end
        ISSUE: if (can_issue) begin
          oRomAddr <= {sr, sc};
          if (last_pos) begin
            state <= DRAIN;
          end else begin
            col <= col + 1'b1;
            if (&col) row <= row + 1'b1;
          end
        end
        DRAIN: if (pop && head_eof) begin
          state <= DONE;
          oBusy <= 1'b0;
          oDone <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // ---- in-flight pipe: _p0 = address cycle, _p(PL-1) = data cycle ----
      vld_p <= {vld_p[PL-2:0], can_issue};

      // ---- output FIFO ----
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    tag_p[0] <= issue_tag;
    for (int i = 1; i < PL; i++) tag_p[i] <= tag_p[i-1];
    if (push) begin
      mem_data[wr_ptr] <= iRomData;
      mem_tag[wr_ptr]  <= tag_p[PL-1];
    end
  end

endmodule

// File: tb/tb_rom_frame_streamer.sv
// Scoreboard bench for rom_frame_streamer: a 4x4 image, one DUT with ROM latency 1
// and one with ROM latency 3, each fed by a ROM model where ROM[a] = a.
`timescale 1ns/1ps
module tb_rom_frame_streamer;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
    logic [1:0] r;
    logic       s;
    logic       e;
    logic       f;
  } pix_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, flip_h, flip_v;
  logic       start0, ready0, busy0, done0, valid0, sof0, eol0, eof0;
  logic [3:0] addr0;
  logic [7:0] romd0, data0;
  logic [1:0] col0, row0;
  logic       start1, ready1, busy1, done1, valid1, sof1, eol1, eof1;
  logic [3:0] addr1, a1_d1, a1_d2;
  logic [7:0] romd1, data1;
  logic [1:0] col1, row1;

  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt0 = 0;
  pix_t q0[$];
  pix_t q1[$];

  rom_frame_streamer #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .PIXEL_BITS(8),
                       .ROM_LATENCY(1), .FIFO_DEPTH(4)) u0 (
    .clock(clock), .reset_n(reset_n), .iStart(start0), .iFlipH(flip_h), .iFlipV(flip_v),
    .oBusy(busy0), .oDone(done0), .oRomAddr(addr0), .iRomData(romd0),
    .oValid(valid0), .iReady(ready0), .oData(data0), .oCol(col0), .oRow(row0),
    .oSof(sof0), .oEol(eol0), .oEof(eof0));

  rom_frame_streamer #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .PIXEL_BITS(8),
                       .ROM_LATENCY(3), .FIFO_DEPTH(4)) u1 (
    .clock(clock), .reset_n(reset_n), .iStart(start1), .iFlipH(flip_h), .iFlipV(flip_v),
    .oBusy(busy1), .oDone(done1), .oRomAddr(addr1), .iRomData(romd1),
    .oValid(valid1), .iReady(ready1), .oData(data1), .oCol(col1), .oRow(row1),
    .oSof(sof1), .oEol(eol1), .oEof(eof1));

  // ROM models: data follows the address by exactly 1 and 3 cycles.
  always @(posedge clock) begin
    romd0 <= {4'h0, addr0};
    a1_d1 <= addr1;
    a1_d2 <= a1_d1;
    romd1 <= {4'h0, a1_d2};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected raster: output order is always (row, col) ascending; the data is the
  // storage address after mirroring.
  task automatic fill(input bit which, input bit fh, input bit fv);
    pix_t p;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p.d = 8'((fv ? 3 - r : r) * 4 + (fh ? 3 - c : c));
        p.c = 2'(c);
        p.r = 2'(r);
        p.s = (r == 0) && (c == 0);
        p.e = (c == 3);
        p.f = (r == 3) && (c == 3);
        if (which) q1.push_back(p);
        else       q0.push_back(p);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (valid0) begin
        if (q0.size() == 0) chk("u0 extra pixel", 32'(valid0), 32'd0);
        else begin
          chk("u0 pixel", 32'({data0, col0, row0, sof0, eol0, eof0}), 32'(q0[0]));
          if (ready0) void'(q0.pop_front());
        end
      end
      if (valid1) begin
        if (q1.size() == 0) chk("u1 extra pixel", 32'(valid1), 32'd0);
        else begin
          chk("u1 pixel", 32'({data1, col1, row1, sof1, eol1, eof1}), 32'(q1[0]));
          if (ready1) void'(q1.pop_front());
        end
      end
      if (done0) done_cnt0++;
    end
  end

  task automatic start_frame0(input bit fh, input bit fv);
    int lat;
    fill(1'b0, fh, fv);
    @(posedge clock); #1;
    start0 = 1'b1; flip_h = fh; flip_v = fv;
    @(posedge clock); #1;
    start0 = 1'b0; flip_h = ~fh; flip_v = ~fv;
    chk("busy rise", 32'(busy0), 32'd1);
    lat = 0;
    while (!valid0 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("first pixel latency", 32'(lat), 32'd3);
  endtask

  task automatic finish0(output int t);
    t = 0;
    while (q0.size() != 0 && t < 400) begin
      @(posedge clock); #1;
      t++;
    end
    chk("u0 queue drained", 32'(q0.size()), 32'd0);
    chk("done pulse", 32'(done0), 32'd1);
    chk("busy fall", 32'(busy0), 32'd0);
  endtask

  task automatic run_std(input bit fh, input bit fv);
    int t;
    start_frame0(fh, fv);
    finish0(t);
    @(posedge clock); #1;
    chk("done one cycle", 32'(done0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t, dc;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    flip_h = 1'b0; flip_v = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    #2;
    chk("u0 reset outputs", 32'({busy0, done0, valid0, addr0, data0, col0, row0, sof0, eol0, eof0}), 32'd0);
    chk("u1 reset outputs", 32'({busy1, done1, valid1, addr1, data1, col1, row1, sof1, eol1, eof1}), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // plain, flip H, flip V, both
    run_std(1'b0, 1'b0);
    run_std(1'b1, 1'b0);
    run_std(1'b0, 1'b1);
    run_std(1'b1, 1'b1);

    // ROM latency 3 with random backpressure
    fill(1'b1, 1'b0, 1'b0);
    flip_h = 1'b0; flip_v = 1'b0;
    @(posedge clock); #1; start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    t = 0;
    while (q1.size() != 0 && t < 600) begin
      ready1 = ($urandom_range(0, 9) >= 3);
      @(posedge clock); #1;
      t++;
    end
    ready1 = 1'b1;
    chk("u1 queue drained", 32'(q1.size()), 32'd0);
    chk("u1 done pulse", 32'(done1), 32'd1);

    // downstream stalled from the start: credits stop issue after four reads
    ready0 = 1'b0;
    start_frame0(1'b0, 1'b0);
    repeat (17) begin @(posedge clock); #1; end
    chk("stall last addr", 32'(addr0), 32'd3);
    chk("stall held data", 32'({valid0, data0}), 32'h100);
    ready0 = 1'b1;
    finish0(t);
    chk("back-to-back after release", 32'(t), 32'd16);
    @(posedge clock); #1;

    // iStart while busy and during the done cycle is ignored
    start_frame0(1'b0, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;
    finish0(t);
    start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;
    chk("done cleared", 32'(done0), 32'd0);
    repeat (30) begin @(posedge clock); #1; end
    chk("no restart busy", 32'(busy0), 32'd0);
    chk("no restart valid", 32'(valid0), 32'd0);

    // reset in the middle of a frame
    start_frame0(1'b0, 1'b0);
    t = 0;
    while (q0.size() > 10 && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    reset_n = 1'b0;
    #1;
    chk("mid reset outputs", 32'({busy0, done0, valid0, addr0, data0, col0, row0, sof0, eol0, eof0}), 32'd0);
    q0.delete();
    dc = done_cnt0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (10) begin @(posedge clock); #1; end
    chk("no done after reset", 32'(done_cnt0 - dc), 32'd0);
    chk("idle after reset", 32'({busy0, valid0}), 32'd0);
    run_std(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
